// File: rtl/writeback_queue.sv
// writeback_queue: buffered driver for the RegisterFile write port (we3/a3/wd3).
//
// Writeback results come in over a valid/ready handshake and are held in an in-order
// circular buffer. They drain into the RegisterFile one per cycle while drain_en grants
// the port. Pending values are forwarded onto rd1/rd2 so decode never reads a stale
// register.
//
// Optional feature: define WBQ_BYPASS_EN to let an input offered to an empty queue
// with drain_en high drive the write port directly in the same cycle.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   in_valid/in_ready   writeback handshake; in_addr/in_data carry the result
//   drain_en            write port granted this cycle
//   we3, a3, wd3        RegisterFile write port
//   a1, a2              decode read addresses
//   rf_rd1, rf_rd2      raw RegisterFile read data
//   rd1, rd2            forwarded operands
//   count               number of queued entries
module writeback_queue #(
    parameter int unsigned REG_BITS  = 32,
    parameter int unsigned ADDR_BITS = 5,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_BITS-1:0]     in_addr,
    input  logic [REG_BITS-1:0]      in_data,
    input  logic                     drain_en,
    output logic                     we3,
    output logic [ADDR_BITS-1:0]     a3,
    output logic [REG_BITS-1:0]      wd3,
    input  logic [ADDR_BITS-1:0]     a1,
    input  logic [ADDR_BITS-1:0]     a2,
    input  logic [REG_BITS-1:0]      rf_rd1,
    input  logic [REG_BITS-1:0]      rf_rd2,
    output logic [REG_BITS-1:0]      rd1,
    output logic [REG_BITS-1:0]      rd2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_BITS-1:0] addr_q [DEPTH];
    logic [REG_BITS-1:0]  data_q [DEPTH];
    logic [PtrW-1:0]      head_q, head_d;
    logic [PtrW-1:0]      tail_q, tail_d;
    logic [CntW-1:0]      count_q, count_d;

    logic empty, full, push, pop, enq, byp;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CntW'(DEPTH));
        in_ready = rst && !full;
        // Writes to the zero register complete the handshake but are dropped.
        push     = in_valid && in_ready && (in_addr != '0);
`ifdef WBQ_BYPASS_EN
        byp      = rst && empty && drain_en && in_valid && (in_addr != '0);
`else
        byp      = 1'b0;
`endif
        // rst gating keeps a stale head from being written in the reset cycle.
        pop      = rst && drain_en && !empty;
        enq      = push && !byp;
    end

    always_comb begin
        we3 = pop || byp;
        a3  = '0;
        wd3 = '0;
        if (!empty) begin
            a3  = addr_q[head_q];
            wd3 = data_q[head_q];
        end else if (byp) begin
            a3  = in_addr;
            wd3 = in_data;
        end
    end

    always_comb begin
        head_d  = pop ? head_q + 1'b1 : head_q;
        tail_d  = enq ? tail_q + 1'b1 : tail_q;
        count_d = count_q + CntW'(enq) - CntW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= in_addr;
            data_q[tail_q] <= in_data;
        end
    end

    // Scan oldest to youngest so the youngest match wins. The head entry still
    // forwards while it is being written, as the RegisterFile updates at the edge.
    always_comb begin : fwd
        logic [PtrW-1:0] idx;
        idx = '0;
        rd1 = rf_rd1;
        rd2 = rf_rd2;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PtrW'(i);
            if (CntW'(i) < count_q) begin
                if (addr_q[idx] == a1) rd1 = data_q[idx];
                if (addr_q[idx] == a2) rd2 = data_q[idx];
            end
        end
        if (a1 == '0) rd1 = '0;
        if (a2 == '0) rd2 = '0;
    end

    assign count = count_q;

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;

    localparam int unsigned RB = 32;
    localparam int unsigned AB = 5;
    localparam int unsigned DP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AB-1:0] in_addr;
    logic [RB-1:0] in_data;
    logic          drain_en;
    logic          we3;
    logic [AB-1:0] a3;
    logic [RB-1:0] wd3;
    logic [AB-1:0] a1, a2;
    logic [RB-1:0] rf_rd1, rf_rd2;
    logic [RB-1:0] rd1, rd2;
    logic [2:0]    count;

    writeback_queue #(.REG_BITS(RB), .ADDR_BITS(AB), .DEPTH(DP)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .drain_en (drain_en),
        .we3      (we3),
        .a3       (a3),
        .wd3      (wd3),
        .a1       (a1),
        .a2       (a2),
        .rf_rd1   (rf_rd1),
        .rf_rd2   (rf_rd2),
        .rd1      (rd1),
        .rd2      (rd2),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AB-1:0] a;
        logic [RB-1:0] d;
    } ent_t;

    ent_t          sb[$];
    logic [RB-1:0] rfm [32];
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            mon_en   = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Youngest pending write to addr wins, otherwise the raw RegisterFile value.
    function automatic logic [RB-1:0] fwd_model(input logic [AB-1:0] addr,
                                                input logic [RB-1:0] raw);
        logic [RB-1:0] v;
        v = raw;
        foreach (sb[i]) if (sb[i].a == addr) v = sb[i].d;
        if (addr == '0) v = '0;
        return v;
    endfunction

    // Scoreboard monitor: inputs are stable from posedge+1 until the next posedge,
    // so the negedge sees exactly what the coming edge will act on.
    always @(negedge clk) begin
        if (mon_en) begin : mon
            logic exp_rdy, exp_we, exp_byp;
            ent_t e;
            exp_rdy = rst && (sb.size() != DP);
            exp_byp = 1'b0;
`ifdef WBQ_BYPASS_EN
            exp_byp = (sb.size() == 0) && drain_en && in_valid && (in_addr != '0);
`endif
            exp_we = rst && drain_en && ((sb.size() != 0) || exp_byp);
            check_eq("mon_count", 64'(count), 64'(sb.size()));
            check_eq("mon_ready", 64'(in_ready), 64'(exp_rdy));
            check_eq("mon_we3", 64'(we3), 64'(exp_we));
            check_eq("mon_rd1", 64'(rd1), 64'(fwd_model(a1, rf_rd1)));
            check_eq("mon_rd2", 64'(rd2), 64'(fwd_model(a2, rf_rd2)));
            if (sb.size() == 0 && !exp_byp) begin
                check_eq("mon_a3_idle", 64'(a3), 64'd0);
                check_eq("mon_wd3_idle", 64'(wd3), 64'd0);
            end
            if (!rst) begin
                sb.delete();
            end else begin
                if (in_valid && exp_rdy && in_addr != '0) sb.push_back({in_addr, in_data});
                if (exp_we) begin
                    if (sb.size() == 0) begin
                        check_eq("mon_sb_underflow", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("mon_a3", 64'(a3), 64'(e.a));
                        check_eq("mon_wd3", 64'(wd3), 64'(e.d));
                        rfm[e.a] = e.d;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic offer(input logic [AB-1:0] a, input logic [RB-1:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
    endtask

    initial begin
        foreach (rfm[i]) rfm[i] = '0;
        rst = 1'b0; drain_en = 1'b1; a1 = '0; a2 = '0; rf_rd1 = '0; rf_rd2 = '0;
        offer(5'd1, 32'd77);

        // Reset held for two edges with in_valid high.
        step();
        mon_en = 1'b1;
        settle();
        check_eq("rst_ready_0", 64'(in_ready), 64'd0);
        check_eq("rst_we3_0", 64'(we3), 64'd0);
        check_eq("rst_count_0", 64'(count), 64'd0);
        step();
        settle();
        check_eq("rst_ready_1", 64'(in_ready), 64'd0);
        check_eq("rst_we3_1", 64'(we3), 64'd0);
        rst = 1'b1;
        in_valid = 1'b0;
        settle();
        check_eq("rst_release_ready", 64'(in_ready), 64'd1);

        // Single write.
        step();
        offer(5'd1, 32'd13);
        step();
        in_valid = 1'b0;
        a1 = 5'd1;
        settle();
        check_eq("single_we3", 64'(we3), 64'd1);
        check_eq("single_a3", 64'(a3), 64'd1);
        check_eq("single_wd3", 64'(wd3), 64'd13);
        check_eq("single_fwd", 64'(rd1), 64'd13);
        step();
        settle();
        check_eq("single_count", 64'(count), 64'd0);
        rf_rd1 = rfm[1];
        settle();
        check_eq("single_rf_read", 64'(rd1), 64'd13);

        // Fill and stall.
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(AB'(2 + i), RB'(20 + i));
            step();
        end
        offer(5'd6, 32'd24);
        settle();
        check_eq("fill_count", 64'(count), 64'd4);
        check_eq("fill_ready", 64'(in_ready), 64'd0);
        step();
        settle();
        check_eq("fill_hold", 64'(count), 64'd4);
        drain_en = 1'b1;
        settle();
        check_eq("drain_a3_0", 64'(a3), 64'd2);
        step();
        settle();
        check_eq("drain_count3", 64'(count), 64'd3);
        check_eq("drain_a3_1", 64'(a3), 64'd3);
        check_eq("drain_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        settle();
        check_eq("fifth_accepted", 64'(count), 64'd3);
        check_eq("drain_a3_2", 64'(a3), 64'd4);
        step(); step(); step();
        settle();
        check_eq("drain_empty", 64'(count), 64'd0);

        // Forwarding priority.
        drain_en = 1'b0;
        offer(5'd7, 32'd100);
        step();
        offer(5'd7, 32'd200);
        step();
        in_valid = 1'b0;
        rf_rd1 = 32'd5; a1 = 5'd7; a2 = 5'd8; rf_rd2 = 32'h55;
        settle();
        check_eq("fwd_youngest", 64'(rd1), 64'd200);
        check_eq("fwd_miss", 64'(rd2), 64'h55);
        drain_en = 1'b1;
        step(); step();
        settle();
        check_eq("fwd_drained", 64'(rd1), 64'd5);

        // Zero register.
        offer(5'd0, 32'hFFFF);
        settle();
        check_eq("zero_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        a1 = 5'd0; rf_rd1 = 32'd9;
        settle();
        check_eq("zero_count", 64'(count), 64'd0);
        check_eq("zero_we3", 64'(we3), 64'd0);
        check_eq("zero_rd1", 64'(rd1), 64'd0);

        // Reset mid-operation.
        drain_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer(AB'(10 + i), RB'(1 + i));
            step();
        end
        in_valid = 1'b0;
        settle();
        check_eq("mid_count3", 64'(count), 64'd3);
        rst = 1'b0;
        drain_en = 1'b1;
        settle();
        check_eq("mid_rst_we3", 64'(we3), 64'd0);
        step();
        settle();
        check_eq("mid_rst_count", 64'(count), 64'd0);
        rst = 1'b1;
        settle();
        check_eq("mid_post_we3", 64'(we3), 64'd0);

        // Empty queue write: bypass in the same cycle, or one cycle later.
        offer(5'd9, 32'd42);
        settle();
`ifdef WBQ_BYPASS_EN
        check_eq("byp_we3", 64'(we3), 64'd1);
        check_eq("byp_a3", 64'(a3), 64'd9);
        check_eq("byp_wd3", 64'(wd3), 64'd42);
`else
        check_eq("nobyp_we3", 64'(we3), 64'd0);
`endif
        step();
        in_valid = 1'b0;
        settle();
`ifdef WBQ_BYPASS_EN
        check_eq("byp_count", 64'(count), 64'd0);
`else
        check_eq("nobyp_count", 64'(count), 64'd1);
        check_eq("nobyp_a3", 64'(a3), 64'd9);
`endif
        step();

        // Random traffic; the monitor checks every cycle.
        for (int c = 0; c < 300; c++) begin
            bit stalled;
            stalled = in_valid && !in_ready;
            step();
            if (!stalled) begin
                in_valid = 1'($urandom_range(0, 1));
                in_addr  = AB'($urandom_range(0, 7));
                in_data  = $urandom;
            end
            drain_en = ($urandom_range(0, 2) != 0);
            a1 = AB'($urandom_range(0, 7));
            a2 = AB'($urandom_range(0, 7));
            rf_rd1 = $urandom;
            rf_rd2 = $urandom;
        end
        in_valid = 1'b0;
        drain_en = 1'b1;
        for (int c = 0; c < 8; c++) step();
        settle();
        check_eq("final_empty", 64'(count), 64'd0);
        check_eq("final_sb_empty", 64'(sb.size()), 64'd0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
